mul_div_unit: RTL and testbench

//  Parametrised multiply/divide unit with architectural HI/LO registers for the EX stage.

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the EX stage.
// Radix-2 iterative shift-add multiplier and restoring divider share one
// 2*WIDTH accumulator. Signed ops run on magnitudes; signs are fixed at the end.
// Op codes are parameters so they can be bound to the ALU decoder encoding.
module mul_div_unit #(
    parameter int         WIDTH            = 32,
    parameter int         MUL_SINGLE_CYCLE = 0,
    parameter logic [4:0] ALU_MULT         = 5'd16,
    parameter logic [4:0] ALU_MULTU        = 5'd17,
    parameter logic [4:0] ALU_DIV          = 5'd18,
    parameter logic [4:0] ALU_DIVU         = 5'd19,
    parameter logic [4:0] ALU_MTHI         = 5'd20,
    parameter logic [4:0] ALU_MTLO         = 5'd21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, next_state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opr;        // multiplicand or divisor magnitude
    logic                 op_div;
    logic                 neg_res;    // negate product / quotient at completion
    logic                 neg_rem;    // negate remainder at completion

    logic is_mul, is_dv, signed_op, single_mul, accept;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul     = (alucontrol == ALU_MULT) || (alucontrol == ALU_MULTU);
    assign is_dv      = (alucontrol == ALU_DIV)  || (alucontrol == ALU_DIVU);
    assign signed_op  = (alucontrol == ALU_MULT) || (alucontrol == ALU_DIV);
    assign single_mul = (MUL_SINGLE_CYCLE != 0) && is_mul;
    assign accept     = start && !flush && (state == IDLE);
    assign a_neg      = signed_op && a[WIDTH-1];
    assign b_neg      = signed_op && b[WIDTH-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;

    assign busy  = (state == BUSY);
    assign stall = busy || (start && !flush && (is_mul || is_dv) && !single_mul);

    // Full-width product for the single-cycle multiply option (modulo 2^(2W)).
    logic [2*WIDTH-1:0] a_ext, b_ext, sc_prod;
    assign a_ext   = {{WIDTH{a_neg ? 1'b1 : 1'b0}}, a};
    assign b_ext   = {{WIDTH{b_neg ? 1'b1 : 1'b0}}, b};
    assign sc_prod = a_ext * b_ext;

    // One radix-2 step of whichever engine is running.
    logic [WIDTH:0]       mul_sum, rem_t, rem_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   step, fin_mul;
    logic [WIDTH-1:0]     fin_q, fin_r;
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
        rem_t   = acc[2*WIDTH-1:WIDTH-1];
        div_ge  = (rem_t >= {1'b0, opr});
        rem_sub = rem_t - {1'b0, opr};
        if (op_div)
            step = {(div_ge ? rem_sub[WIDTH-1:0] : rem_t[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            step = {mul_sum, acc[WIDTH-1:1]};
        fin_mul = neg_res ? -step : step;
        fin_q   = neg_res ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        fin_r   = neg_rem ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: enter BUSY on an iterative accept, leave on last step or flush.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && ((is_mul && !single_mul) || is_dv)) next_state = BUSY;
            BUSY: if (flush || cnt == CW'(1)) next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and HI/LO writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0; lo <= '0; done <= 1'b0; cnt <= '0;
            acc <= '0; opr <= '0; op_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (single_mul) begin
                        {hi, lo} <= sc_prod;
                        done     <= 1'b1;
                    end else if (is_mul) begin
                        acc     <= {{WIDTH{1'b0}}, b_mag};
                        opr     <= a_mag;
                        op_div  <= 1'b0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= 1'b0;
                        cnt     <= CW'(WIDTH);
                    end else if (is_dv) begin
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opr     <= b_mag;
                        op_div  <= 1'b1;
                        // divide by zero keeps the all-ones quotient unsigned-looking
                        neg_res <= (a_neg ^ b_neg) && (b != '0);
                        neg_rem <= a_neg;
                        cnt     <= CW'(WIDTH);
                    end else if (alucontrol == ALU_MTHI) begin
                        hi <= a;
                    end else if (alucontrol == ALU_MTLO) begin
                        lo <= a;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        acc <= step;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            if (op_div) begin
                                hi <= fin_r;
                                lo <= fin_q;
                            end else begin
                                {hi, lo} <= fin_mul;
                            end
                            done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: iterative instance (dut0) and single-cycle-multiply
// instance (dut1), directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;
    localparam logic [4:0] OP_MULT = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18,
                           OP_DIVU = 5'd19, OP_MTHI  = 5'd20, OP_MTLO = 5'd21;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, start0 = 1'b0, start1 = 1'b0;
    logic [4:0]  alucontrol = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy0, stall0, done0, busy1, stall1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;
    int          errors = 0, checks = 0;
    logic        busy1_seen = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .MUL_SINGLE_CYCLE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .start(start0), .alucontrol(alucontrol),
        .a(a), .b(b), .busy(busy0), .stall(stall0), .done(done0), .hi(hi0), .lo(lo0));

    mul_div_unit #(.WIDTH(32), .MUL_SINGLE_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .start(start1), .alucontrol(alucontrol),
        .a(a), .b(b), .busy(busy1), .stall(stall1), .done(done1), .hi(hi1), .lo(lo1));

    always @(posedge clk) if (busy1) busy1_seen <= 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        longint p;
        sx = x; sy = y;
        case (op)
            OP_MULT:  begin p = longint'(sx) * longint'(sy); return p; end
            OP_MULTU: return {32'b0, x} * {32'b0, y};
            OP_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Issue one iterative op on dut0, count busy cycles, check result and done pulse.
    task automatic run_iter(input string tag, input logic [4:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [63:0] exp);
        int n;
        logic early_done;
        @(negedge clk);
        alucontrol = op; a = x; b = y; start0 = 1'b1;
        #1 chk({tag, "_stall"}, {63'b0, stall0}, 64'd1);
        @(negedge clk);
        start0 = 1'b0;
        n = 0; early_done = 1'b0;
        while (busy0 && n < 100) begin
            if (done0) early_done = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_done"}, {62'b0, early_done, done0}, 64'd1);
        chk({tag, "_hilo"}, {hi0, lo0}, exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'b0, done0}, 64'd0);
    endtask

    task automatic mt(input logic [4:0] op, input logic [31:0] x);
        @(negedge clk);
        alucontrol = op; a = x; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("mt_busy_done", {62'b0, busy0, done0}, 64'd0);
        chk("mt_value", 64'(op == OP_MTHI ? hi0 : lo0), 64'(x));
    endtask

    initial begin
        logic [4:0]  op, ops[4];
        logic [31:0] x, y, px, py;
        logic [4:0]  pop;
        logic        saw_done;
        int          n;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

        repeat (2) @(negedge clk);
        chk("reset_state", {hi0, lo0}, 64'h0);
        chk("reset_flags", {61'b0, busy0, done0, stall0}, 64'h0);
        rst = 1'b0;

        run_iter("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_iter("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_iter("divu_7", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC);
        run_iter("divu_by0", OP_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
        run_iter("div_by0_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF);
        run_iter("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(3)];
            x = $urandom; y = $urandom;
            if ($urandom_range(7) == 0) y = 0;
            if ($urandom_range(3) == 0) y = y >> $urandom_range(31);
            run_iter("random", op, x, y, model(op, x, y));
        end

        // MTHI/MTLO then a flushed divide leaves HI/LO alone and never signals done.
        mt(OP_MTHI, 32'h1234);
        mt(OP_MTLO, 32'h5678);
        @(negedge clk); alucontrol = OP_DIV; a = 32'd100; b = 32'd7; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_busy", {63'b0, busy0}, 64'd0);
        chk("flush_hilo", {hi0, lo0}, 64'h0000_1234_0000_5678);
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        chk("flush_no_done", {63'b0, saw_done}, 64'd0);

        // Reset mid-operation clears everything asynchronously.
        @(negedge clk); alucontrol = OP_DIV; a = 32'd1000; b = 32'd3; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_hilo", {hi0, lo0}, 64'h0);
        chk("rst_mid_busy", {63'b0, busy0}, 64'd0);
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done0) saw_done = 1'b1; end
        chk("rst_no_done", {63'b0, saw_done}, 64'd0);

        // start while busy is ignored; flush beats a same-cycle start.
        mt(OP_MTHI, 32'hAAAA);
        @(negedge clk); alucontrol = OP_DIVU; a = 32'd50; b = 32'd7; start0 = 1'b1;
        @(negedge clk); alucontrol = OP_MTHI; a = 32'hDEAD;
        #1 chk("busy_start_stall", {63'b0, stall0}, 64'd1);
        repeat (3) @(negedge clk);
        chk("busy_start_ignored", 64'(hi0), 64'hAAAA);
        start0 = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin n++; @(negedge clk); end
        chk("busy_start_result", {hi0, lo0}, 64'h0000_0001_0000_0007);
        @(negedge clk); alucontrol = OP_MTLO; a = 32'hBEEF; start0 = 1'b1; flush = 1'b1;
        #1 chk("flush_start_stall", {63'b0, stall0}, 64'd0);
        @(negedge clk); start0 = 1'b0; flush = 1'b0;
        chk("flush_start_lo", 64'(lo0), 64'd7);

        // Single-cycle multiply instance.
        @(negedge clk); alucontrol = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd4; start1 = 1'b1;
        #1 chk("sc_stall", {63'b0, stall1}, 64'd0);
        @(negedge clk);
        chk("sc_mult", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("sc_done", {62'b0, busy1, done1}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            pop = $urandom_range(1) ? OP_MULT : OP_MULTU;
            px = $urandom; py = $urandom;
            alucontrol = pop; a = px; b = py;
            #1 chk("sc_b2b_stall", {63'b0, stall1}, 64'd0);
            @(negedge clk);
            chk("sc_b2b", {hi1, lo1}, model(pop, px, py));
            chk("sc_b2b_done", {63'b0, done1}, 64'd1);
        end
        start1 = 1'b0;
        @(negedge clk);
        chk("sc_done_drop", {63'b0, done1}, 64'd0);
        chk("sc_never_busy", {63'b0, busy1_seen}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
